// File: rtl/gray_seq_source.sv
// gray_seq_source: Gray-code word source with an up/down binary count, a valid/ready output and a terminal-count flag.
// Latency: out_valid rises one cycle after en is sampled in IDLE; the count advances on the edge that ends each transfer.
// Backpressure: with out_ready low the word and out_valid hold steady; en, up_dn and load are ignored until the next transfer.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   en         run request; dropping it ends RUN on the next transfer
//   up_dn      direction (1 = up, 0 = down), sampled on each transfer
//   load       load request, honoured in IDLE only (priority over en)
//   load_gray  Gray value converted to binary and loaded into the count
//   out_ready  downstream ready
//   out_valid  gray_out/bin_out hold a valid word (high in RUN)
//   gray_out   cnt ^ (cnt >> 1)
//   bin_out    cnt
//   tc         combinational terminal-count flag for the current transfer
//   err        sticky single-bit-transition error
//
// Build option: define GRAY_SEQ_CHECK_EN to build the transition checker
// that drives err; otherwise err is tied low.

module gray_seq_source #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_gray,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc,
  output logic         err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] MAX  = '1;

  state_t       state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic [N-1:0] load_bin;
  logic         xfer;
  logic         load_take;

  assign out_valid = (state == RUN);
  assign xfer      = out_valid & out_ready;
  assign load_take = (state == IDLE) & load;
  assign gray_out  = cnt ^ (cnt >> 1);
  assign bin_out   = cnt;
  assign tc        = xfer & ((up_dn & (cnt == MAX)) | (~up_dn & (cnt == ZERO)));

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin        = '0;
    load_bin[N-1]   = load_gray[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ load_gray[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          cnt_nxt = load_bin;
        end else if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_nxt = up_dn ? (cnt + ONE) : (cnt - ONE);
          // The word leaving with en low is the last one of the run.
          if (!en) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GRAY_SEQ_CHECK_EN
  logic [N-1:0] last_gray;
  logic         hist_vld;
  logic         err_q;

  function automatic int unsigned ones(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < N; i++) c += {31'd0, v[i]};
    return c;
  endfunction

  // History holds the previous transferred word; a load breaks the sequence,
  // so the first word after it is not compared.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gray <= '0;
      hist_vld  <= 1'b0;
      err_q     <= 1'b0;
    end else if (load_take) begin
      hist_vld <= 1'b0;
    end else if (xfer) begin
      last_gray <= gray_out;
      hist_vld  <= 1'b1;
      if (hist_vld && (ones(gray_out ^ last_gray) != 1)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/gray_seq_source.md
GRAY_SEQ_SOURCE -- requirements
Module: gray_seq_source

Interface
REQ-001 Parameter: N, default 4, counter/code width in bits (N >= 2).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: en  input  1  request to run the sequence.
REQ-005 Port: up_dn  input  1  direction (1 = count up, 0 = count down), sampled on each transfer.
REQ-006 Port: load  input  1  load request, honoured in IDLE only.
REQ-007 Port: load_gray  input  N  Gray value loaded when load is honoured.
REQ-008 Port: out_ready  input  1  downstream (Gray-to-binary converter stage) ready.
REQ-009 Port: out_valid  output  1  gray_out/bin_out hold a valid word.
REQ-010 Port: gray_out  output  N  current Gray code word (feeds converter `in` with mode=1).
REQ-011 Port: bin_out  output  N  binary equivalent of gray_out (golden reference for converter output).
REQ-012 Port: tc  output  1  terminal-count flag.
REQ-013 Port: err  output  1  sticky sequence-error flag.

Function
REQ-014 The block SHALL hold an N-bit binary count cnt; gray_out SHALL equal cnt ^ (cnt >> 1) and bin_out SHALL equal cnt at all times.
REQ-015 The FSM SHALL have two states: IDLE (out_valid=0) and RUN (out_valid=1).
REQ-016 IDLE -> RUN on the cycle after en=1 is sampled and load=0; out_valid rises one cycle after en.
REQ-017 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-018 On a transfer, cnt SHALL become cnt+1 (up_dn=1) or cnt-1 (up_dn=0) modulo 2^N: 2^N-1 wraps to 0 and 0 wraps to 2^N-1.
REQ-019 In RUN without a transfer, gray_out, bin_out and out_valid SHALL remain stable, regardless of en, up_dn or load.
REQ-020 RUN -> IDLE when a transfer occurs with en=0 in the same cycle; cnt still advances on that transfer.
REQ-021 In IDLE with load=1, cnt SHALL take the binary conversion of load_gray on the next edge: bit N-1 equals load_gray[N-1], and each lower bit i equals bin[i+1] ^ load_gray[i].
REQ-022 In IDLE, load takes priority over en; the state stays IDLE that cycle.
REQ-023 load SHALL be ignored in RUN.
REQ-024 tc SHALL be combinational: out_valid & out_ready & ((up_dn & cnt==2^N-1) | (~up_dn & cnt==0)).

Reset
REQ-025 While rst=1 at a rising clk edge, the block SHALL enter IDLE with cnt=0, out_valid=0, gray_out=0, bin_out=0, err=0, and the checker history invalidated.
REQ-026 Reset SHALL override load, en and any transfer in progress in the same cycle.
REQ-027 Reset mid-RUN SHALL drop out_valid on the next edge without completing the pending transfer.

Configuration
REQ-028 Macro GRAY_SEQ_CHECK_EN SHALL control the single-bit-transition checker.
REQ-029 With GRAY_SEQ_CHECK_EN defined, the block SHALL register gray_out on each transfer.
REQ-030 With GRAY_SEQ_CHECK_EN defined, err SHALL set and stay set until reset if any two consecutive transferred words differ in a bit count other than exactly 1.
REQ-031 With GRAY_SEQ_CHECK_EN defined, the checker history SHALL be invalidated by load and by reset.
REQ-032 With GRAY_SEQ_CHECK_EN undefined, err SHALL be tied to 0 and no checker logic SHALL be built.

Verification (N=4)
REQ-033 Up-count: reset, en=1, up_dn=1, out_ready=1 for 17 cycles -> gray_out 0000,0001,0011,0010,0110,... ; tc high with gray_out=1000 (bin 1111); next word 0000.
REQ-034 Down-count with wrap: load_gray=0000 in IDLE, then en=1, up_dn=0, out_ready=1 -> bin_out 0,15,14; tc high with bin_out=0.
REQ-035 Backpressure: in RUN with bin_out=5, out_ready=0 for 3 cycles while up_dn and load toggle -> gray_out stays 0111 and out_valid stays 1; next ready transfer gives bin_out=6 (gray 0101).
REQ-036 Load: in IDLE, load=1, load_gray=1100 -> bin_out=1000 next cycle, out_valid=0; load=1 asserted in RUN -> no change.
REQ-037 Stop and reset: en=0 with out_ready=1 in RUN -> one final transfer, then out_valid=0; rst=1 mid-RUN with bin_out=9 -> next cycle out_valid=0, bin_out=0, err=0.
REQ-038 Checker (macro defined): 20 cycles of wrapping up-count -> err stays 0; forcing cnt to jump by 3 -> err=1 until rst.
